// File: rtl/coef_pkg.sv
// coef_pkg: shared widths and FSM encoding for the loadable coefficient RAM
package coef_pkg;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 3;
   localparam int BYTE_W = 8;
   localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;
endpackage

// File: rtl/coef_byte_pack.sv
// coef_byte_pack: MSB-first byte-to-word shift register with byte counter
module coef_byte_pack
   import coef_pkg::*;
#(
   parameter int DATA_W = coef_pkg::DATA_W,
   parameter int BYTE_W = coef_pkg::BYTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] din,
   input  logic              accept,
   output logic [DATA_W-1:0] word,
   output logic              word_full
);
   localparam int NB = DATA_W / BYTE_W;
   localparam int CNT_W = $clog2(NB);
   logic [CNT_W-1:0] byte_cnt;
   assign word_full = accept && byte_cnt == CNT_W'(NB - 1);
   // counter wraps to 0 on the byte that completes the word
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         byte_cnt <= '0;
         word <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + CNT_W'(1);
         word <= {word[DATA_W-BYTE_W-1:0], din};
      end
endmodule

// File: rtl/coef_ram_wr.sv
// coef_ram_wr: 8x64 coefficient RAM loaded from a byte stream, two registered read ports
module coef_ram_wr
   import coef_pkg::*;
#(
   parameter int DATA_W = coef_pkg::DATA_W,
   parameter int ADDR_W = coef_pkg::ADDR_W,
   parameter int BYTE_W = coef_pkg::BYTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [BYTE_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              load_busy,
   output logic              load_done,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   output logic [DATA_W-1:0] dout1,
   output logic [DATA_W-1:0] dout2
);
   state_t state;
   logic [ADDR_W-1:0] word_cnt;
   logic [DATA_W-1:0] word;
   logic word_full;
   logic [DATA_W-1:0] mem [2**ADDR_W];

   coef_byte_pack #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_pack (
      .clk(clk),
      .rst_n(rst_n),
      .din(din),
      .accept(din_valid && din_ready),
      .word(word),
      .word_full(word_full)
   );

   // outputs are registered alongside the next state
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_IDLE;
         word_cnt <= '0;
         din_ready <= 1'b0;
         load_busy <= 1'b0;
         load_done <= 1'b0;
      end else
         case (state)
            ST_IDLE:
               if (load_start) begin
                  state <= ST_LOAD;
                  din_ready <= 1'b1;
                  load_busy <= 1'b1;
               end
            ST_LOAD:
               if (word_full) begin
                  state <= ST_WRITE;
                  din_ready <= 1'b0;
               end
            ST_WRITE: begin
               word_cnt <= word_cnt + ADDR_W'(1);
               if (&word_cnt) begin
                  state <= ST_DONE;
                  load_busy <= 1'b0;
                  load_done <= 1'b1;
               end else begin
                  state <= ST_LOAD;
                  din_ready <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               load_done <= 1'b0;
            end
         endcase

   // reads sample mem before the same-edge write lands, giving old-data semantics
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem <= '{default: '0};
         dout1 <= '0;
         dout2 <= '0;
      end else begin
         if (state == ST_WRITE) mem[word_cnt] <= word;
         dout1 <= mem[addr1];
         dout2 <= mem[addr2];
      end
endmodule

// File: tb/tb_coef_ram_wr.sv
// tb_coef_ram_wr: directed checks of stream loading, read timing and reset abort
module tb_coef_ram_wr;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_start = 1'b0;
   logic [7:0] din = '0;
   logic din_valid = 1'b0;
   logic din_ready, load_busy, load_done;
   logic [2:0] addr1 = '0, addr2 = '0;
   logic [63:0] dout1, dout2;
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int done_base;

   coef_ram_wr dut (
      .clk(clk),
      .rst_n(rst_n),
      .load_start(load_start),
      .din(din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .load_busy(load_busy),
      .load_done(load_done),
      .addr1(addr1),
      .addr2(addr2),
      .dout1(dout1),
      .dout2(dout2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (load_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wexp(input int w);
      logic [63:0] r = '0;
      for (int k = 0; k < 8; k++) r = {r[55:0], 8'(8 * w + k)};
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      din = b;
      din_valid = 1'b1;
      while (din_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", 64'(n < 100), 64'd1);
      @(negedge clk);
      din_valid = 1'b0;
      if (b[2:0] == 3'd7) begin
         check("write_ready_low", 64'(din_ready), 64'd0);
         check("write_busy", 64'(load_busy), 64'd1);
      end
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic finish_load(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(load_done), 64'd1);
      check({tag, "_busy_in_done"}, 64'(load_busy), 64'd0);
      @(negedge clk);
      check({tag, "_done_clear"}, 64'(load_done), 64'd0);
      check({tag, "_done_count"}, 64'(done_cnt - done_base), 64'd1);
   endtask

   task automatic read_check(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                             input logic [63:0] e1, input logic [63:0] e2);
      addr1 = a1;
      addr2 = a2;
      @(negedge clk);
      check({tag, "_dout1"}, dout1, e1);
      check({tag, "_dout2"}, dout2, e2);
   endtask

   initial begin
      // 1: reset state and all-zero reads
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_ready", 64'(din_ready), 64'd0);
      check("rst_busy", 64'(load_busy), 64'd0);
      check("rst_done", 64'(load_done), 64'd0);
      for (int i = 0; i < 8; i++) read_check("rst_read", 3'(i), 3'(7 - i), 64'h0, 64'h0);
      // 2: continuous-valid load
      done_base = done_cnt;
      pulse_start();
      check("load_busy", 64'(load_busy), 64'd1);
      check("load_ready", 64'(din_ready), 64'd1);
      for (int b = 0; b < 64; b++) send_byte(8'(b));
      finish_load("cont");
      read_check("cont_w0w7", 3'd0, 3'd7, 64'h0001020304050607, 64'h38393A3B3C3D3E3F);
      read_check("cont_w3", 3'd3, 3'd3, 64'h18191A1B1C1D1E1F, 64'h18191A1B1C1D1E1F);
      for (int i = 0; i < 8; i++) read_check("cont_all", 3'(i), 3'(7 - i), wexp(i), wexp(7 - i));
      // 3: valid toggling every cycle
      done_base = done_cnt;
      pulse_start();
      for (int b = 0; b < 64; b++) begin
         @(negedge clk);
         send_byte(8'(b));
      end
      finish_load("togl");
      for (int i = 0; i < 8; i++) read_check("togl_all", 3'(i), 3'(7 - i), wexp(i), wexp(7 - i));
      // 6: reset in the middle of word 5
      done_base = done_cnt;
      addr1 = 3'd3;
      addr2 = 3'd5;
      pulse_start();
      for (int b = 0; b < 44; b++) send_byte(8'(b));
      check("pre_abort_busy", 64'(load_busy), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_dout1", dout1, 64'h0);
      check("abort_dout2", dout2, 64'h0);
      check("abort_ready", 64'(din_ready), 64'd0);
      check("abort_busy", 64'(load_busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      read_check("abort_mem", 3'd0, 3'd4, 64'h0, 64'h0);
      read_check("abort_mem2", 3'd3, 3'd7, 64'h0, 64'h0);
      check("abort_no_done", 64'(done_cnt - done_base), 64'd0);
      check("abort_idle_ready", 64'(din_ready), 64'd0);
      // 4+5: fresh load, same-address read across write, ignored restart
      done_base = done_cnt;
      pulse_start();
      for (int b = 0; b < 23; b++) send_byte(8'(b));
      addr1 = 3'd2;
      addr2 = 3'd2;
      send_byte(8'd23);
      check("wr2_before", dout1, 64'h0);
      @(negedge clk);
      check("wr2_old_1", dout1, 64'h0);
      check("wr2_old_2", dout2, 64'h0);
      @(negedge clk);
      check("wr2_new_1", dout1, 64'h1011121314151617);
      check("wr2_new_2", dout2, 64'h1011121314151617);
      pulse_start();
      check("restart_busy", 64'(load_busy), 64'd1);
      for (int b = 24; b < 64; b++) send_byte(8'(b));
      finish_load("fresh");
      repeat (3) @(negedge clk);
      check("fresh_single_done", 64'(done_cnt - done_base), 64'd1);
      check("fresh_idle_ready", 64'(din_ready), 64'd0);
      for (int i = 0; i < 8; i++) read_check("fresh_all", 3'(i), 3'(7 - i), wexp(i), wexp(7 - i));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
